muldiv_unit: RTL and testbench

Multi-cycle multiply/divide unit in the execute stage, consuming the `muldiv_funct`, `write_hi`, `write_lo` and `hilo_src` control produced by the instruction decoder. It owns the architectural HI/LO registers. It performs MULT/MULTU in a fixed short latency and DIV/DIVU with a radix-2 restoring divider. It also services MTHI/MTLO writes and exposes `busy` so the hazard unit can stall MFHI/MFLO and further mul/div issue.

---
 rtl/muldiv_unit.sv | 172 +++++++++++++++++
 tb/tb_muldiv_unit.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/muldiv_unit.sv
// HI/LO multiply/divide unit: one-cycle multiply and radix-2 restoring divide.
// Divide-by-zero takes the multiply path and returns hi=a, lo=all-ones.
package selector;
  typedef enum logic [2:0] {
    MULDIV_NCARE,
    MULDIV_MULT,
    MULDIV_MULTU,
    MULDIV_DIV,
    MULDIV_DIVU
  } muldiv_funct_t;
endpackage

module muldiv_unit
  import selector::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  muldiv_funct_t    funct,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             flush,
  input  logic             wr_hi,
  input  logic             wr_lo,
  input  logic [WIDTH-1:0] wdata,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CW = $clog2(WIDTH);

  typedef enum logic [2:0] {
    S_IDLE, S_MUL, S_DIV, S_SIGN, S_DONE
  } state_t;

  state_t           r_state, w_next;
  logic [WIDTH-1:0] r_hi, r_lo;
  logic [WIDTH-1:0] r_a, r_b;
  logic [WIDTH-1:0] r_rem, r_quo, r_dvs;
  logic [CW-1:0]    r_cnt;
  logic             r_signed, r_dz;
  logic             r_negq, r_negr;

  logic             w_busy, w_is_mul, w_is_div;
  logic             w_sgn, w_bz, w_go;
  logic [WIDTH-1:0] w_amag, w_bmag;
  logic [2*WIDTH-1:0] w_ea, w_eb, w_prod;
  logic [WIDTH:0]   w_rsh;
  logic [WIDTH+1:0] w_diff;
  logic             w_ge, w_unused;
  logic [WIDTH-1:0] w_rem_nx, w_quo_nx;
  logic [WIDTH-1:0] w_q_fin, w_r_fin;

  assign w_busy = (r_state == S_MUL) || (r_state == S_DIV) ||
                  (r_state == S_SIGN);
  assign busy   = w_busy;
  assign done   = (r_state == S_DONE);
  assign hi     = r_hi;
  assign lo     = r_lo;

  always_comb begin
    w_is_mul = 1'b0;
    w_is_div = 1'b0;
    w_sgn    = 1'b0;
    unique case (1'b1)
      funct == MULDIV_MULT:  begin w_is_mul = 1'b1; w_sgn = 1'b1; end
      funct == MULDIV_MULTU: w_is_mul = 1'b1;
      funct == MULDIV_DIV:   begin w_is_div = 1'b1; w_sgn = 1'b1; end
      funct == MULDIV_DIVU:  w_is_div = 1'b1;
      default: ;
    endcase
  end

  assign w_bz   = (b == '0);
  assign w_go   = start && !w_busy && !flush && (w_is_mul || w_is_div);
  assign w_amag = (w_sgn && a[WIDTH-1]) ? -a : a;
  assign w_bmag = (w_sgn && b[WIDTH-1]) ? -b : b;

  // Sign-extend to 2W so one modular multiply covers MULT and MULTU.
  assign w_ea   = {{WIDTH{r_signed & r_a[WIDTH-1]}}, r_a};
  assign w_eb   = {{WIDTH{r_signed & r_b[WIDTH-1]}}, r_b};
  assign w_prod = w_ea * w_eb;

  assign w_rsh    = {r_rem, r_quo[WIDTH-1]};
  assign w_diff   = {1'b0, w_rsh} - {2'b00, r_dvs};
  assign w_ge     = ~w_diff[WIDTH+1];
  assign w_unused = w_diff[WIDTH];
  assign w_rem_nx = w_ge ? w_diff[WIDTH-1:0] : w_rsh[WIDTH-1:0];
  assign w_quo_nx = {r_quo[WIDTH-2:0], w_ge};
  assign w_q_fin  = r_negq ? -r_quo : r_quo;
  assign w_r_fin  = r_negr ? -r_rem : r_rem;

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE, S_DONE: begin
        w_next = S_IDLE;
        if (w_go)
          w_next = (w_is_div && !w_bz) ? S_DIV : S_MUL;
      end
      S_MUL:  w_next = S_DONE;
      S_DIV:  if (r_cnt == CW'(WIDTH-1)) w_next = S_SIGN;
      S_SIGN: w_next = S_DONE;
      default: w_next = S_IDLE;
    endcase
    if (flush) w_next = S_IDLE;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_state <= S_IDLE;
    else          r_state <= w_next;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_a      <= '0;
      r_b      <= '0;
      r_rem    <= '0;
      r_quo    <= '0;
      r_dvs    <= '0;
      r_cnt    <= '0;
      r_signed <= 1'b0;
      r_dz     <= 1'b0;
      r_negq   <= 1'b0;
      r_negr   <= 1'b0;
    end else if (w_go) begin
      r_a      <= a;
      r_b      <= b;
      r_signed <= w_sgn;
      r_dz     <= w_is_div && w_bz;
      r_quo    <= w_amag;
      r_dvs    <= w_bmag;
      r_rem    <= '0;
      r_cnt    <= '0;
      r_negq   <= w_sgn && (a[WIDTH-1] ^ b[WIDTH-1]);
      r_negr   <= w_sgn && a[WIDTH-1];
    end else if (r_state == S_DIV) begin
      r_rem <= w_rem_nx;
      r_quo <= w_quo_nx;
      r_cnt <= r_cnt + CW'(1);
    end
  end

  // Result edges can only occur while busy, so they always beat MTHI/MTLO.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_hi <= '0;
      r_lo <= '0;
    end else if (!flush) begin
      if (r_state == S_MUL) begin
        if (r_dz) begin
          r_hi <= r_a;
          r_lo <= {WIDTH{1'b1}};
        end else begin
          r_hi <= w_prod[2*WIDTH-1:WIDTH];
          r_lo <= w_prod[WIDTH-1:0];
        end
      end else if (r_state == S_SIGN) begin
        r_hi <= w_r_fin;
        r_lo <= w_q_fin;
      end else if (!w_busy) begin
        if (wr_hi) r_hi <= wdata;
        if (wr_lo) r_lo <= wdata;
      end
    end
  end

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed bench for muldiv_unit: latency, results, flush, MTHI/MTLO
// and asynchronous reset behaviour.
module tb_muldiv_unit;
  import selector::*;

  logic          clk;
  logic          reset_n;
  logic          start;
  muldiv_funct_t funct;
  logic [31:0]   a, b, wdata;
  logic          flush, wr_hi, wr_lo;
  logic          busy, done;
  logic [31:0]   hi, lo;

  int checks = 0;
  int errors = 0;
  int lat;
  bit bz;
  bit seen;

  muldiv_unit #(.WIDTH(32)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .funct(funct),
    .a(a), .b(b), .flush(flush), .wr_hi(wr_hi), .wr_lo(wr_lo),
    .wdata(wdata), .busy(busy), .done(done), .hi(hi), .lo(lo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Called at a falling edge (cycle 0); returns the cycle done is seen.
  task automatic run(input muldiv_funct_t f, input logic [31:0] x,
                     input logic [31:0] y, output int l, output bit bh);
    start = 1'b1; funct = f; a = x; b = y;
    @(negedge clk);
    start = 1'b0; funct = MULDIV_NCARE;
    l = 1; bh = 1'b1;
    while (!done && l < 100) begin
      if (!busy) bh = 1'b0;
      @(negedge clk);
      l++;
    end
  endtask

  initial begin
    reset_n = 1'b0; start = 1'b0; funct = MULDIV_NCARE;
    a = '0; b = '0; wdata = '0;
    flush = 1'b0; wr_hi = 1'b0; wr_lo = 1'b0;
    #2;
    chk("rst_busy", {31'b0, busy}, 32'd0);
    chk("rst_done", {31'b0, done}, 32'd0);
    chk("rst_hi", hi, 32'h0);
    chk("rst_lo", lo, 32'h0);
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);

    start = 1'b1; funct = MULDIV_NCARE;
    @(negedge clk);
    start = 1'b0;
    chk("ncare_busy", {31'b0, busy}, 32'd0);
    @(negedge clk);
    chk("ncare_done", {31'b0, done}, 32'd0);

    run(MULDIV_MULT, 32'hFFFF_FFFE, 32'h3, lat, bz);
    chk("mult_lat", lat, 2);
    chk("mult_busy", {31'b0, bz}, 32'd1);
    chk("mult_notbusy", {31'b0, busy}, 32'd0);
    chk("mult_hi", hi, 32'hFFFF_FFFF);
    chk("mult_lo", lo, 32'hFFFF_FFFA);
    @(negedge clk);
    chk("mult_pulse", {31'b0, done}, 32'd0);

    run(MULDIV_MULTU, 32'hFFFF_FFFE, 32'h3, lat, bz);
    chk("multu_lat", lat, 2);
    chk("multu_hi", hi, 32'h2);
    chk("multu_lo", lo, 32'hFFFF_FFFA);
    @(negedge clk);

    run(MULDIV_DIV, 32'hFFFF_FFF9, 32'h2, lat, bz);
    chk("div_lat", lat, 34);
    chk("div_busy", {31'b0, bz}, 32'd1);
    chk("div_lo", lo, 32'hFFFF_FFFD);
    chk("div_hi", hi, 32'hFFFF_FFFF);
    @(negedge clk);

    run(MULDIV_DIVU, 32'd100, 32'd7, lat, bz);
    chk("divu_lat", lat, 34);
    chk("divu_lo", lo, 32'd14);
    chk("divu_hi", hi, 32'd2);
    @(negedge clk);

    run(MULDIV_DIV, 32'h8000_0000, 32'hFFFF_FFFF, lat, bz);
    chk("ovf_lo", lo, 32'h8000_0000);
    chk("ovf_hi", hi, 32'h0);
    @(negedge clk);

    run(MULDIV_DIVU, 32'd5, 32'd0, lat, bz);
    chk("dz_lat", lat, 2);
    chk("dz_hi", hi, 32'd5);
    chk("dz_lo", lo, 32'hFFFF_FFFF);
    @(negedge clk);

    wr_hi = 1'b1; wdata = 32'hAAAA_0000;
    @(negedge clk);
    wr_hi = 1'b0;
    chk("mthi_idle", hi, 32'hAAAA_0000);
    wr_hi = 1'b1; wr_lo = 1'b1; wdata = 32'h1234;
    @(negedge clk);
    wr_lo = 1'b1; wr_hi = 1'b0; wdata = 32'h5678;
    @(negedge clk);
    wr_lo = 1'b0;
    chk("mthi_1234", hi, 32'h1234);
    chk("mtlo_5678", lo, 32'h5678);

    start = 1'b1; funct = MULDIV_DIVU; a = 32'd100; b = 32'd7;
    @(negedge clk);
    start = 1'b0; funct = MULDIV_NCARE;
    wr_lo = 1'b1; wdata = 32'hDEAD_BEEF;
    @(negedge clk);
    wr_lo = 1'b0;
    chk("mtlo_busy", lo, 32'h5678);
    chk("flush_prebusy", {31'b0, busy}, 32'd1);
    repeat (8) @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    chk("flush_busy", {31'b0, busy}, 32'd0);
    chk("flush_done", {31'b0, done}, 32'd0);
    seen = 1'b0;
    repeat (40) begin
      @(negedge clk);
      if (done || busy) seen = 1'b1;
    end
    chk("flush_quiet", {31'b0, seen}, 32'd0);
    chk("flush_hi", hi, 32'h1234);
    chk("flush_lo", lo, 32'h5678);

    run(MULDIV_DIV, 32'd100, 32'd7, lat, bz);
    chk("b2b_div_lat", lat, 34);
    chk("b2b_div_lo", lo, 32'd14);
    run(MULDIV_MULT, 32'd7, 32'd6, lat, bz);
    chk("b2b_mul_lat", lat, 2);
    chk("b2b_mul_hi", hi, 32'd0);
    chk("b2b_mul_lo", lo, 32'd42);

    wr_hi = 1'b1; wdata = 32'h55;
    @(negedge clk);
    wr_hi = 1'b0;
    chk("mthi_done", hi, 32'h55);

    start = 1'b1; funct = MULDIV_DIVU; a = 32'd9; b = 32'd2;
    @(negedge clk);
    start = 1'b0; funct = MULDIV_NCARE;
    repeat (5) @(negedge clk);
    chk("arst_prebusy", {31'b0, busy}, 32'd1);
    #2 reset_n = 1'b0;
    #1;
    chk("arst_busy", {31'b0, busy}, 32'd0);
    chk("arst_done", {31'b0, done}, 32'd0);
    chk("arst_hi", hi, 32'h0);
    chk("arst_lo", lo, 32'h0);
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    chk("arst_idle_busy", {31'b0, busy}, 32'd0);
    @(negedge clk);
    chk("arst_idle_done", {31'b0, done}, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
